aes_inv_subbytes_seq: RTL and testbench



---
 rtl/aes_inv_subbytes_seq.sv | 166 ++++++++++++++++
 tb/tb_aes_inv_subbytes_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine: BYTES_PER_CYCLE shared inverse S-boxes, valid/ready in and out.
// Optional macro AES_INV_SHIFTROWS_EN fuses InvShiftRows into the accept-edge load.
module aes_inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int B       = BYTES_PER_CYCLE;
    localparam int NGROUPS = 16 / B;
    localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

    if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      sb_in  [B];
    logic [7:0]      sb_out [B];

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Value loaded into the working register on the accept edge.
    function automatic logic [127:0] load_value(input logic [127:0] s);
`ifdef AES_INV_SHIFTROWS_EN
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
`else
        return s;
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < B; i++) begin
            sb_in[i] = work_q[127 - 8*(int'(cnt_q)*B + i) -: 8];
        end
    end

    for (genvar g = 0; g < B; g++) begin : g_sbox
        assign sb_out[g] = inv_sbox(sb_in[g]);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d     = load_value(in_state);
                    cnt_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                for (int i = 0; i < B; i++) begin
                    work_d[127 - 8*(int'(cnt_q)*B + i) -: 8] = sb_out[i];
                end
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the working register is reset too, so out_state reads zero and no stale state survives reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Scoreboard bench for aes_inv_subbytes_seq: main B=4 instance plus a B=1/2/8/16 sweep.
module tb_aes_inv_subbytes_seq;

    localparam logic [0:15][127:0] SBOX_ROWS = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [127:0] T2_IN = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef AES_INV_SHIFTROWS_EN
    localparam logic [127:0] T2_EXP = 128'h000d0a0704010e0b0805020f0c090603;
`else
    localparam logic [127:0] T2_EXP = 128'h000102030405060708090a0b0c0d0e0f;
`endif
    localparam int SW_B [4] = '{1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_state, out_state;
    logic         sw_in_valid;
    logic [127:0] sw_in_state;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_out_state [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(SW_B[g])) u_sw (
            .clk(clk), .rst(rst),
            .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]), .in_state(sw_in_state),
            .out_valid(sw_out_valid[g]), .out_ready(1'b1), .out_state(sw_out_state[g])
        );
    end

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[127 - 8*int'(x[3:0]) -: 8];
    endfunction

    // Expected-value model of the optional InvShiftRows permutation.
    function automatic logic [127:0] model_perm(input logic [127:0] s);
`ifdef AES_INV_SHIFTROWS_EN
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
        return o;
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] st, input logic [127:0] exp);
        int n = 0;
        in_state = st;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'd0, 128'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_state = ~st;
        exp_q.push_back(exp);
    endtask

    task automatic recv(input string tag);
        int n = 0;
        logic [127:0] e;
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
            out_ready = 1'b0;
            return;
        end
        check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'd4);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, out_state, e);
        end
        @(posedge clk); #1;
        check({tag, "_valid_clr"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_set"}, 128'(in_ready), 128'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] st, ex;
        bit seen [4];
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        out_ready = 1'b0;
        sw_in_valid = 1'b0;
        sw_in_state = '0;
        #23;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(T2_IN, T2_EXP);
        recv("t2");

        // Reset mid-BUSY discards the in-flight state.
        send(T2_IN, T2_EXP);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_state", out_state, 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send({16{8'h63}}, 128'd0);
        recv("after_rst");

        // Backpressure: hold DONE for 5 cycles with a competing input.
        send(T2_IN, T2_EXP);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("bp_valid", 128'(out_valid), 128'd1);
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_hold_ready", 128'(in_ready), 128'd0);
            check("bp_hold_state", out_state, T2_EXP);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() != 0) ex = exp_q.pop_front();
        else ex = '1;
        check("bp_state", out_state, ex);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_valid_clr", 128'(out_valid), 128'd0);
        check("bp_ready_set", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        check("bp_no_accept", 128'(in_ready), 128'd1);

        // Exhaustive ROM: state j carries Sbox(16j+k) in byte k.
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) begin
                st[127 - 8*k -: 8] = sbox(8'(16*j + k));
                ex[127 - 8*k -: 8] = 8'(16*j + k);
            end
            send(st, model_perm(ex));
            recv($sformatf("rom_%0d", j));
        end
        send({16{8'hed}}, {16{8'h53}});
        recv("spot_ed");
        send({16{8'h16}}, {16{8'hff}});
        recv("spot_16");

        // Parameter sweep on the T2 vector.
        for (int g = 0; g < 4; g++) begin
            seen[g] = 1'b0;
            check($sformatf("sweep_b%0d_idle", SW_B[g]), 128'(sw_in_ready[g]), 128'd1);
        end
        sw_in_state = T2_IN;
        sw_in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sw_in_valid = 1'b0;
        sw_in_state = '0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    check($sformatf("sweep_b%0d_latency", SW_B[g]), 128'(cyc - acc_cyc), 128'(16 / SW_B[g]));
                    check($sformatf("sweep_b%0d_state", SW_B[g]), sw_out_state[g], T2_EXP);
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("sweep_b%0d_seen", SW_B[g]), 128'(seen[g]), 128'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
